// File: rtl/psum_arb_pkg.sv
// Shared types and sizing helpers for the global-buffer partial-sum arbiters.
package psum_arb_pkg;

    typedef enum logic [2:0] {StIdle, StArb, StXfer, StDrain, StDone} arb_state_e;

    localparam int unsigned NUM_CH_DEF    = 3;
    localparam int unsigned BURST_LEN_DEF = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_IDX_W = idx_w(NUM_CH_DEF);
    localparam int unsigned BURST_W  = idx_w(BURST_LEN_DEF + 1);

endpackage

// File: rtl/rr_arb_sel.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping modulo NUM.
module rr_arb_sel
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM  = NUM_CH_DEF,
    parameter int unsigned IdxW = CH_IDX_W
) (
    input  logic [NUM-1:0]  req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] grant,
    output logic            any
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the closest requester is written last.
    always_comb begin
        grant = '0;
        any   = |req;
        idx   = 0;
        for (int unsigned k = 0; k < NUM; k++) begin
            idx = (32'(ptr) + (NUM - 1 - k)) % NUM;
            if (req[idx]) begin
                grant = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/psum_gb_arb.sv
// Shares the GB partial-sum write port among the PEB output channels with round-robin
// burst arbitration, per-channel address generation and end-of-block detection.
module psum_gb_arb
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned PSUM_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CH_STRIDE  = 1024,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned CNT_WIDTH  = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [CNT_WIDTH-1:0]         cfg_words,
    input  logic [NUM_CH-1:0]            psum_val,
    input  logic [NUM_CH*PSUM_WIDTH-1:0] psum_data,
    output logic [NUM_CH-1:0]            psum_rdy,
    output logic                         gb_val,
    output logic [ADDR_WIDTH-1:0]        gb_addr,
    output logic [PSUM_WIDTH-1:0]        gb_data,
    input  logic                         gb_rdy,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned IdxW   = (idx_w(NUM_CH) > CH_IDX_W) ? idx_w(NUM_CH) : CH_IDX_W;
    localparam int unsigned BurstW = (idx_w(BURST_LEN + 1) > BURST_W) ?
                                     idx_w(BURST_LEN + 1) : BURST_W;

    arb_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]    words_q, words_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_CH];
    logic [IdxW-1:0]         grant_q, grant_d, rr_q, rr_d, sel;
    logic [BurstW-1:0]       burst_q, burst_d;
    logic                    gb_val_q, gb_val_d;
    logic [ADDR_WIDTH-1:0]   gb_addr_q, gb_addr_d;
    logic [PSUM_WIDTH-1:0]   gb_data_q, gb_data_d;
    logic [PSUM_WIDTH-1:0]   ch_data [NUM_CH];
    logic [NUM_CH-1:0]       elig;
    logic                    any_elig, all_done, adv, accept, g_open, leave;
    logic [CNT_WIDTH-1:0]    cnt_g;

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = psum_data[i*PSUM_WIDTH +: PSUM_WIDTH];
            elig[i]    = psum_val[i] && (cnt_q[i] < words_q);
            if (cnt_q[i] != words_q) begin
                all_done = 1'b0;
            end
        end
    end

    rr_arb_sel #(
        .NUM  (NUM_CH),
        .IdxW (IdxW)
    ) u_sel (
        .req   (elig),
        .ptr   (rr_q),
        .grant (sel),
        .any   (any_elig)
    );

    assign adv    = !gb_val_q || gb_rdy;
    assign cnt_g  = cnt_q[grant_q];
    assign g_open = cnt_g < words_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            psum_rdy[i] = (state_q == StXfer) && (grant_q == IdxW'(i)) && adv && g_open;
        end
    end

    assign accept = |(psum_val & psum_rdy);

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        burst_d   = burst_q;
        gb_val_d  = gb_val_q;
        gb_addr_d = gb_addr_q;
        gb_data_d = gb_data_q;
        leave     = 1'b0;

        // Output stage reloads whenever it is empty or being drained this cycle.
        if (adv) begin
            gb_val_d = accept;
            if (accept) begin
                gb_addr_d = ADDR_WIDTH'(grant_q) * ADDR_WIDTH'(CH_STRIDE) + ADDR_WIDTH'(cnt_g);
                gb_data_d = ch_data[grant_q];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    words_d = (cfg_words > CNT_WIDTH'(CH_STRIDE)) ? CNT_WIDTH'(CH_STRIDE)
                                                                  : cfg_words;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_d[i] = '0;
                    end
                    burst_d = '0;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (all_done) begin
                    state_d = StDrain;
                end else if (any_elig) begin
                    grant_d = sel;
                    burst_d = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    cnt_d[grant_q] = cnt_g + 1'b1;
                    burst_d        = burst_q + 1'b1;
                    leave = (burst_q + 1'b1 == BurstW'(BURST_LEN)) || (cnt_g + 1'b1 == words_q);
                end else if (adv && (!psum_val[grant_q] || !g_open)) begin
                    leave = 1'b1;
                end
                if (leave) begin
                    rr_d    = (grant_q == IdxW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                    state_d = StArb;
                end
            end
            StDrain: begin
                if (adv) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            words_q   <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            burst_q   <= '0;
            gb_val_q  <= 1'b0;
            gb_addr_q <= '0;
            gb_data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            burst_q   <= burst_d;
            gb_val_q  <= gb_val_d;
            gb_addr_q <= gb_addr_d;
            gb_data_q <= gb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gb_val  = gb_val_q;
    assign gb_addr = gb_addr_q;
    assign gb_data = gb_data_q;
    assign busy    = (state_q == StArb) || (state_q == StXfer) || (state_q == StDrain);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_psum_gb_arb.sv
// Directed bench for psum_gb_arb: each source beat carries {channel, beat index} so every
// GB write can be checked against its expected channel address and order.
module tb_psum_gb_arb;

    localparam int unsigned NCH = 3;
    localparam int unsigned PW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned STRIDE = 1024;
    localparam int unsigned CW = 11;

    logic              clk = 1'b0;
    logic              rst, cfg_start, gb_rdy, gb_val, busy, done;
    logic [CW-1:0]     cfg_words;
    logic [NCH-1:0]    psum_val, psum_rdy;
    logic [NCH*PW-1:0] psum_data;
    logic [AW-1:0]     gb_addr;
    logic [PW-1:0]     gb_data;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int beat [NCH];
    int next_exp [NCH];
    logic [AW-1:0] wr_addr [$];

    always #5 clk = ~clk;

    psum_gb_arb dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_words (cfg_words),
        .psum_val  (psum_val),
        .psum_data (psum_data),
        .psum_rdy  (psum_rdy),
        .gb_val    (gb_val),
        .gb_addr   (gb_addr),
        .gb_data   (gb_data),
        .gb_rdy    (gb_rdy),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NCH; i++) begin
            psum_data[i*PW +: PW] = (64'(i) << 32) | 64'(beat[i]);
        end
    endtask

    task automatic new_block(input int words);
        cfg_words = CW'(words);
        done_cnt = 0;
        wr_addr.delete();
        for (int i = 0; i < NCH; i++) begin
            beat[i] = 0;
            next_exp[i] = 0;
        end
        drive_data();
    endtask

    function automatic logic [AW-1:0] wa(input int k);
        return (k < wr_addr.size()) ? wr_addr[k] : 'x;
    endfunction

    // One clock: sample before the edge, advance, then update source data and hold checks.
    task automatic step();
        logic [NCH-1:0] acc;
        logic           hold;
        logic [AW-1:0]  ha;
        logic [PW-1:0]  hd;
        int             ch;
        #1;
        acc = psum_val & psum_rdy;
        hold = !rst && gb_val && !gb_rdy;
        ha = gb_addr;
        hd = gb_data;
        if (hold) chk("stall_rdy", 64'(psum_rdy), 64'd0);
        if (!rst && done) done_cnt++;
        if (!rst && gb_val && gb_rdy) begin
            wr_addr.push_back(gb_addr);
            ch = int'(gb_data[63:32]);
            chk("sb_chan", 64'(ch < NCH), 64'd1);
            if (ch < NCH) begin
                chk("sb_addr", 64'(gb_addr), 64'(ch * STRIDE + next_exp[ch]));
                chk("sb_beat", 64'(gb_data[31:0]), 64'(next_exp[ch]));
                next_exp[ch]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (acc[i]) beat[i]++;
        end
        drive_data();
        if (hold) begin
            chk("hold_val", 64'(gb_val), 64'd1);
            chk("hold_addr", 64'(gb_addr), 64'(ha));
            chk("hold_data", gb_data, hd);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        psum_val = '0;
        gb_rdy = 1'b0;
        new_block(0);

        // Reset and idle
        repeat (3) step();
        chk("rst_rdy", 64'(psum_rdy), 64'd0);
        chk("rst_gb_val", 64'(gb_val), 64'd0);
        chk("rst_gb_addr", 64'(gb_addr), 64'd0);
        chk("rst_gb_data", gb_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        psum_val = '1;
        gb_rdy = 1'b1;
        step();
        step();
        chk("idle_rdy", 64'(psum_rdy), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Single channel 1, five beats
        psum_val = 3'b010;
        new_block(5);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_arb_rdy", 64'(psum_rdy), 64'd0);
        step();
        chk("s1_xfer_rdy", 64'(psum_rdy), 64'b010);
        chk("s1_gbval0", 64'(gb_val), 64'd0);
        step();
        chk("s1_gbval1", 64'(gb_val), 64'd1);
        chk("s1_addr0", 64'(gb_addr), 64'd1024);
        chk("s1_data0", gb_data, 64'h1_0000_0000);
        repeat (12) step();
        chk("s1_nwr", 64'(wr_addr.size()), 64'd5);
        for (int k = 0; k < 5; k++) chk("s1_addr", 64'(wa(k)), 64'(1024 + k));
        chk("s1_nodone", 64'(done_cnt), 64'd0);
        chk("s1_still_busy", 64'(busy), 64'd1);
        psum_val = '1;
        repeat (40) step();
        chk("s1_total_wr", 64'(wr_addr.size()), 64'd15);
        chk("s1_done_once", 64'(done_cnt), 64'd1);
        chk("s1_idle", 64'(busy), 64'd0);

        // Zero-word block
        new_block(0);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("z_busy", 64'(busy), 64'd1);
        chk("z_done_e0", 64'(done), 64'd0);
        step();
        chk("z_done_e1", 64'(done), 64'd0);
        step();
        chk("z_done_e2", 64'(done), 64'd1);
        chk("z_busy_e2", 64'(busy), 64'd0);
        step();
        chk("z_done_e3", 64'(done), 64'd0);
        chk("z_nwr", 64'(wr_addr.size()), 64'd0);

        // Three channels always valid, 8 words each; restart ignored while busy
        rst = 1'b1;
        step();
        rst = 1'b0;
        new_block(8);
        psum_val = '1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (50) step();
        chk("rr_nwr", 64'(wr_addr.size()), 64'd24);
        for (int k = 0; k < 24; k++) begin
            chk("rr_addr", 64'(wa(k)), 64'(((k / 4) % 3) * STRIDE + ((k / 12) * 4) + (k % 4)));
        end
        chk("rr_done", 64'(done_cnt), 64'd1);

        // Random backpressure
        new_block(6);
        psum_val = '1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            gb_rdy = 1'($urandom_range(0, 1));
            step();
        end
        gb_rdy = 1'b1;
        chk("bp_done", 64'(done_cnt), 64'd1);
        chk("bp_nwr", 64'(wr_addr.size()), 64'd18);
        for (int i = 0; i < NCH; i++) chk("bp_chan_cnt", 64'(next_exp[i]), 64'd6);

        // Early release of channel 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        new_block(4);
        psum_val = 3'b011;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (3) step();
        psum_val = 3'b010;
        step();
        chk("er_arb_rdy", 64'(psum_rdy), 64'd0);
        step();
        chk("er_ch1_rdy", 64'(psum_rdy), 64'b010);
        psum_val = 3'b011;
        repeat (20) step();
        chk("er_nwr", 64'(wr_addr.size()), 64'd8);
        chk("er_a0", 64'(wa(0)), 64'd0);
        chk("er_a1", 64'(wa(1)), 64'd1);
        chk("er_a2", 64'(wa(2)), 64'd1024);
        chk("er_a5", 64'(wa(5)), 64'd1027);
        chk("er_a6", 64'(wa(6)), 64'd2);
        chk("er_a7", 64'(wa(7)), 64'd3);
        chk("er_nodone", 64'(done_cnt), 64'd0);

        // Reset while a beat is held under backpressure
        psum_val = 3'b100;
        step();
        gb_rdy = 1'b0;
        step();
        step();
        chk("mr_held_val", 64'(gb_val), 64'd1);
        chk("mr_held_addr", 64'(gb_addr), 64'd2048);
        rst = 1'b1;
        step();
        chk("mr_gb_val", 64'(gb_val), 64'd0);
        chk("mr_gb_addr", 64'(gb_addr), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_rdy", 64'(psum_rdy), 64'd0);
        rst = 1'b0;
        gb_rdy = 1'b1;
        new_block(2);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (10) step();
        chk("mr_nwr", 64'(wr_addr.size()), 64'd2);
        chk("mr_a0", 64'(wa(0)), 64'd2048);
        chk("mr_a1", 64'(wa(1)), 64'd2049);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_gb_arb.md
Name: psum_gb_arb

Overview:
- Shares the single global-buffer partial-sum write port among the PEB's NUM_CH partial-sum output channels (PSUMGB_val/data/rdy 0..2).
- Round-robin arbitration with burst lock; per-channel write-address generation; end-of-block detection.
- Sits between the PEB partial-sum outputs and the GB partial-sum bank.
- Its done output drives the block-level ARBPEB_Fnh/next_block sequencing.

Parameters:
- NUM_CH, 3, number of partial-sum channels.
- PSUM_WIDTH, 64, bits per partial-sum beat.
- ADDR_WIDTH, 12, GB word address width.
- CH_STRIDE, 1024, GB words reserved per channel (power of two, ≤ 2^ADDR_WIDTH/NUM_CH).
- BURST_LEN, 4, maximum accepted beats per grant before the arbiter must re-arbitrate.
- CNT_WIDTH, 11, width of per-channel beat counters (≥ log2(CH_STRIDE)+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_start  in  1  pulse; starts a block, clears counters; ignored unless in IDLE.
- cfg_words  in  CNT_WIDTH  beats expected per channel this block; sampled on cfg_start.
- psum_val  in  NUM_CH  per-channel valid.
- psum_data  in  NUM_CH*PSUM_WIDTH  per-channel data; channel i at [i*PSUM_WIDTH +: PSUM_WIDTH].
- psum_rdy  out  NUM_CH  per-channel ready.
- gb_val  out  1  GB write valid.
- gb_addr  out  ADDR_WIDTH  GB write address.
- gb_data  out  PSUM_WIDTH  GB write data.
- gb_rdy  in  1  GB write ready.
- busy  out  1  high from the cycle after an accepted cfg_start until done.
- done  out  1  one-cycle pulse when all channels have delivered cfg_words beats and the output register is empty.

Behaviour:
- Reset values:
  - psum_rdy=0, gb_val=0, gb_addr=0, gb_data=0, busy=0, done=0.
  - State IDLE; RR pointer=0; all counters 0; output register empty.
  - Reset mid-transfer discards the held beat; no GB write occurs for it.
- Handshakes:
  - Transfer on val&&rdy in the same cycle, both sides.
  - gb_val, once high, holds with gb_addr/gb_data stable until gb_rdy.
- Output register: one stage; latency from upstream accept to gb_val = 1 cycle.
  - adv = !gb_val || gb_rdy.
  - psum_rdy[i] = (state==XFER) && (grant==i) && adv && (cnt[i] < words_q). Registered-grant, combinational rdy.
  - Full throughput: 1 beat/cycle while gb_rdy=1.
- Address: gb_addr = i*CH_STRIDE + cnt[i] at accept; cnt[i] increments on each accepted beat of channel i.
- Channel masking: channel i is eligible when psum_val[i] && cnt[i] < words_q. A completed channel is never granted; its extra val is left pending, not dropped.
- States:
  - IDLE: on cfg_start, latch words_q, clear cnt[] and burst counter, go to ARB.
  - ARB: select the first eligible channel at or after RR pointer (wrapping modulo NUM_CH), set grant, clear burst counter, go to XFER. With none eligible, stay. If all cnt==words_q, go to DRAIN.
  - XFER: count accepted beats. Leave for ARB when:
    - burst counter reaches BURST_LEN, or
    - granted channel's val is low in a cycle where adv=1, or
    - its cnt reaches words_q.
    - On leaving, RR pointer = grant+1 mod NUM_CH.
  - DRAIN: wait for output register empty (gb_val=0, or gb_rdy on last beat). Next cycle: DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Boundaries:
  - cfg_words=0: ARB→DRAIN→DONE; done 2 cycles after start, no GB writes.
  - cfg_start while busy is ignored.
  - Simultaneous requests resolve strictly by RR pointer.
  - cnt never exceeds CH_STRIDE; cfg_words > CH_STRIDE is saturated to CH_STRIDE when latched.
  - Backpressure: gb_rdy=0 stalls all psum_rdy. The burst counter does not advance while stalled.

Decomposition:
- Shared package psum_arb_pkg holds:
  - state enum (IDLE, ARB, XFER, DRAIN, DONE);
  - localparams for channel-index width (clog2 NUM_CH) and burst-counter width.
- One natural sub-module: rr_arb_sel. Pure combinational first-eligible-from-pointer selector, NUM_CH wide, returning grant index and any_eligible; reused by other GB arbiters.

Test Plan:
- Reset/idle: assert rst 3 cycles → all outputs 0; no psum_rdy before cfg_start.
- Single channel, cfg_words=5, ch1 val constant, gb_rdy=1:
  - five beats written to addrs 1024..1028, first gb_val 1 cycle after first accept;
  - done pulses once; ch0/ch2 counts 0 → no done until cfg_words met. Rerun with cfg_words for ch0/ch2 via separate block with cfg_words=0 → done 2 cycles after start.
- All three channels always valid, cfg_words=8, BURST_LEN=4:
  - grant order 0,1,2,0,1,2, each 4 beats;
  - addresses 0-3, 1024-1027, 2048-2051, 4-7, …;
  - done after 24 writes.
- Backpressure: random gb_rdy 50%:
  - gb_data/gb_addr stable while gb_val&&!gb_rdy;
  - no beat lost or duplicated; scoreboard matches per-channel sequences.
- Early release: ch0 drops val after 2 beats → arbiter moves to ch1 within 2 cycles; ch0 resumes later at addr 2.
- Reset mid-burst with gb_val=1, gb_rdy=0 → next cycle gb_val=0, state IDLE, counters 0; a new cfg_start restarts addresses at channel base.
